// File: rtl/veririsc_pkg.sv
// -----------------------------------------------------------------------------
// veririsc_pkg
//   Definitions shared by the VeriRISC controller and datapath.
//   Both blocks import this package, so opcode encodings have one source.
//   Contents:
//     VR_AW, VR_DW : default address and data widths (DW = AW + 3).
//     opcode_e     : 3-bit instruction opcode.
//   Instruction format: {opcode[2:0], operand[AW-1:0]}.
// -----------------------------------------------------------------------------
package veririsc_pkg;

  localparam int VR_AW = 5;
  localparam int VR_DW = 8;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

endpackage

// File: rtl/veririsc_alu.sv
// -----------------------------------------------------------------------------
// veririsc_alu
//   Combinational ALU of the VeriRISC datapath.
//   Ports:
//     opcode  in  opcode_e  operation, taken from the instruction register
//     ac      in  DW        accumulator
//     b       in  DW        memory operand
//     alu_out out DW        result, loaded into AC by ld_ac
//   HLT, SKZ, STO and JMP pass the accumulator through unchanged, so an
//   unexpected ld_ac during those instructions leaves AC intact.
// -----------------------------------------------------------------------------
module veririsc_alu
  import veririsc_pkg::*;
#(
  parameter int DW = VR_DW
) (
  input  opcode_e         opcode,
  input  logic [DW-1:0]   ac,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   alu_out
);

  always_comb begin
    alu_out = ac;
    case (opcode)
      OP_ADD:  alu_out = ac + b;  // carry discarded, wraps modulo 2^DW
      OP_AND:  alu_out = ac & b;
      OP_XOR:  alu_out = ac ^ b;
      OP_LDA:  alu_out = b;
      default: alu_out = ac;
    endcase
  end

endmodule

// File: rtl/veririsc_datapath.sv
// -----------------------------------------------------------------------------
// veririsc_datapath
//   Register datapath of the VeriRISC CPU: PC, IR, AC, ALU and the sticky
//   halt flag. Executes the per-phase strobes issued by the controller
//   against a 32x8 memory.
//   Control strobes are single-cycle level qualifiers, sampled on the rising
//   edge of clk; there is no valid/ready handshake. A strobe is acted on
//   only while halted = 0 (a halt sampled together with a load lets that
//   load complete on the same edge).
//   Ports:
//     clk, reset            clock; asynchronous active-high reset
//     sel                   address mux: 1 = PC, 0 = IR operand
//     rd, wr                memory strobes, gated by halted onto mem_rd/mem_wr
//     ld_ir, ld_ac, ld_pc   register loads; inc_pc increments PC
//     halt                  sets the sticky halted flag
//     data_e                drives AC onto mem_wdata (otherwise 0)
//     mem_rdata             memory read data
//     mem_addr, mem_wdata   memory address / write data
//     mem_rd, mem_wr        gated memory strobes
//     opcode, zero          status to the controller (from IR and AC)
//     halted                sticky halt flag
//     retire_cnt            retired-instruction count
//   Build option: define VERIRISC_RETIRE_CNT_EN to include the saturating
//   16-bit retire counter; otherwise retire_cnt is tied to 0.
// -----------------------------------------------------------------------------
module veririsc_datapath
  import veririsc_pkg::*;
#(
  parameter int AW = VR_AW,
  parameter int DW = VR_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic          rd,
  input  logic          ld_ir,
  input  logic          halt,
  input  logic          inc_pc,
  input  logic          ld_ac,
  input  logic          ld_pc,
  input  logic          wr,
  input  logic          data_e,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [2:0]    opcode,
  output logic          zero,
  output logic          halted,
  output logic [15:0]   retire_cnt
);

  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_ac;
  logic          r_halted;

  opcode_e       w_opcode;
  logic [DW-1:0] w_alu_out;

  assign w_opcode = opcode_e'(r_ir[DW-1:AW]);

  veririsc_alu #(
    .DW (DW)
  ) u_alu (
    .opcode  (w_opcode),
    .ac      (r_ac),
    .b       (mem_rdata),
    .alu_out (w_alu_out)
  );

  // Registers. Once halted, every load is ignored until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_ac     <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (ld_ir) r_ir <= mem_rdata;
      if (ld_ac) r_ac <= w_alu_out;
      // Jump target wins over sequential increment.
      if (ld_pc)       r_pc <= r_ir[AW-1:0];
      else if (inc_pc) r_pc <= r_pc + AW'(1);
      if (halt) r_halted <= 1'b1;
    end
  end

`ifdef VERIRISC_RETIRE_CNT_EN
  logic [15:0] r_retire_cnt;

  // One retirement per instruction fetch; saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (ld_ir && !r_halted && (r_retire_cnt != 16'hFFFF)) begin
      r_retire_cnt <= r_retire_cnt + 16'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = '0;
`endif

  assign mem_addr  = sel ? r_pc : r_ir[AW-1:0];
  assign mem_wdata = data_e ? r_ac : '0;
  assign mem_rd    = rd & ~r_halted;
  assign mem_wr    = wr & ~r_halted;
  assign opcode    = r_ir[DW-1:AW];
  assign zero      = (r_ac == '0);
  assign halted    = r_halted;

endmodule
